// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants and next-pc source select for pc_gen
package pc_gen_pkg;
  localparam int XLEN_DEF = 64;
  localparam logic [63:0] PC_RESET = 64'h8000_0000;
  localparam int RAS_DEPTH_DEF = 4;
  localparam int STEP_32 = 4;
  localparam int STEP_16 = 2;
  typedef enum logic [2:0] {SEL_TRAP, SEL_REDIR, SEL_MISALIGN, SEL_RAS, SEL_SEQ, SEL_HOLD} sel_e;
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch handshake, redirect sources and RAS hints around pc_gen
interface pc_gen_if #(parameter int XLEN = 64) ();
  logic fetch_valid, fetch_ready, inst_len_16;
  logic trap_valid, redir_valid, ras_push, ras_pop;
  logic [XLEN-1:0] trap_target, redir_target, pc, pc_next, misalign_addr;
  logic ras_empty, misalign_err;
  modport master (
    output fetch_valid, pc, pc_next, ras_empty, misalign_err, misalign_addr,
    input fetch_ready, inst_len_16, trap_valid, trap_target, redir_valid, redir_target, ras_push, ras_pop
  );
  modport slave (
    input fetch_valid, pc, pc_next, ras_empty, misalign_err, misalign_addr,
    output fetch_ready, inst_len_16, trap_valid, trap_target, redir_valid, redir_target, ras_push, ras_pop
  );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a full push overwrites the oldest entry
module pc_ras #(
  parameter int XLEN = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, wr_idx;
  logic [CW-1:0] count_q, count_d;
  logic do_rep, do_push, do_pop;
  assign empty = count_q == '0;
  assign top = mem_q[ptr_q - PW'(1)];
  // push+pop on an empty stack degrades to a plain push
  assign do_rep = push & pop & ~empty;
  assign do_push = push & ~do_rep;
  assign do_pop = pop & ~push & ~empty;
  assign wr_idx = do_rep ? ptr_q - PW'(1) : ptr_q;
  always_comb begin
    mem_d = mem_q;
    if (do_push | do_rep) mem_d[wr_idx] = din;
    ptr_d = do_push ? ptr_q + PW'(1) : do_pop ? ptr_q - PW'(1) : ptr_q;
    count_d = do_push ? (count_q == CW'(DEPTH) ? count_q : count_q + CW'(1)) :
              do_pop ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      count_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with trap > redirect > RAS-return priority and misalign reporting
module pc_gen import pc_gen_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] PC_INIT = XLEN'(PC_RESET),
  parameter int RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int C_EXT = 1
) (
  input logic clk,
  input logic rst,
  pc_gen_if.master bus
);
  localparam logic [XLEN-1:0] AMASK = (C_EXT != 0) ? XLEN'(1) : XLEN'(3);
  logic [XLEN-1:0] pc_q, pc_d, seq, ras_top, misalign_addr_q, misalign_addr_d;
  logic fetch_valid_q, misalign_err_q, misalign_err_d;
  logic fire, redir_mis, ras_act, ras_hit, ras_empty;
  sel_e sel;
  assign fire = fetch_valid_q & bus.fetch_ready;
  assign seq = pc_q + ((C_EXT != 0 && bus.inst_len_16) ? XLEN'(STEP_16) : XLEN'(STEP_32));
  assign redir_mis = |(bus.redir_target & AMASK);
  assign ras_act = fire & ~bus.trap_valid & ~bus.redir_valid;
  assign ras_hit = ras_act & bus.ras_pop & ~ras_empty;
  always_comb begin
    sel = bus.trap_valid ? SEL_TRAP :
          bus.redir_valid ? (redir_mis ? SEL_MISALIGN : SEL_REDIR) :
          ras_hit ? SEL_RAS : fire ? SEL_SEQ : SEL_HOLD;
    pc_d = sel == SEL_TRAP ? bus.trap_target & ~AMASK :
           sel == SEL_REDIR ? bus.redir_target :
           sel == SEL_RAS ? ras_top :
           sel == SEL_SEQ ? seq : pc_q;
    misalign_err_d = sel == SEL_MISALIGN;
    misalign_addr_d = misalign_err_d ? bus.redir_target : misalign_addr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= PC_INIT;
      fetch_valid_q <= 1'b0;
      misalign_err_q <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      pc_q <= pc_d;
      fetch_valid_q <= 1'b1;
      misalign_err_q <= misalign_err_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end
  pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .rst(rst),
    .push(ras_act & bus.ras_push),
    .pop(ras_act & bus.ras_pop),
    .din(seq),
    .top(ras_top),
    .empty(ras_empty)
  );
  assign bus.pc = pc_q;
  assign bus.pc_next = rst ? PC_INIT : pc_d;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.ras_empty = ras_empty;
  assign bus.misalign_err = misalign_err_q;
  assign bus.misalign_addr = misalign_addr_q;
endmodule
